// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle CPU control unit.
// Holds the FSM state enum, ALU op / address-select encodings, the bit
// positions of each instruction class in the decoder output and the
// operand-field slice, plus small one-hot helper functions.
package cpu_ctrl_pkg;

  localparam int unsigned DEC_W   = 27;
  localparam int unsigned CLS_W   = 23;
  localparam int unsigned OPF_LSB = 23;
  localparam int unsigned OPF_MSB = 26;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_OPER   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_INWAIT = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_SHL  = 3'd2;
  localparam logic [2:0] ALU_SHR  = 3'd3;
  localparam logic [2:0] ALU_CMP  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_PTR = 2'd1;

  // Instruction-class bit positions in dec_y[22:0]
  localparam int unsigned Y_NOOP    = 0;
  localparam int unsigned Y_INPUTC  = 1;
  localparam int unsigned Y_INPUTCF = 2;
  localparam int unsigned Y_INPUTD  = 3;
  localparam int unsigned Y_INPUTDF = 4;
  localparam int unsigned Y_MOVE    = 5;
  localparam int unsigned Y_LOADI   = 6;
  localparam int unsigned Y_ADD     = 7;
  localparam int unsigned Y_ADDI    = 8;
  localparam int unsigned Y_SUB     = 9;
  localparam int unsigned Y_SUBI    = 10;
  localparam int unsigned Y_LOAD    = 11;
  localparam int unsigned Y_LOADF   = 12;
  localparam int unsigned Y_STORE   = 13;
  localparam int unsigned Y_STOREF  = 14;
  localparam int unsigned Y_SHIFTL  = 15;
  localparam int unsigned Y_SHIFTR  = 16;
  localparam int unsigned Y_CMP     = 17;
  localparam int unsigned Y_JUMP    = 18;
  localparam int unsigned Y_BRE     = 19;
  localparam int unsigned Y_BRNE    = 20;
  localparam int unsigned Y_BRG     = 21;
  localparam int unsigned Y_BRGE    = 22;

  // Isolate the lowest set bit (two's-complement trick)
  function automatic logic [CLS_W-1:0] lowest_set(input logic [CLS_W-1:0] v);
    return v & (~v + CLS_W'(1));
  endfunction

  function automatic logic is_onehot(input logic [CLS_W-1:0] v);
    return (v != '0) && ((v & (v - CLS_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/cpu_branch_eval.sv
// Combinational branch-condition evaluator.
// Ports: i_bre/i_brne/i_brg/i_brge - branch class bits (at most one set),
//        i_flag_z/i_flag_gt - registered ALU flags, o_take - branch taken.
module cpu_branch_eval (
  input  logic i_bre,
  input  logic i_brne,
  input  logic i_brg,
  input  logic i_brge,
  input  logic i_flag_z,
  input  logic i_flag_gt,
  output logic o_take
);

  assign o_take = (i_bre  &  i_flag_z)
                | (i_brne & ~i_flag_z)
                | (i_brg  &  i_flag_gt)
                | (i_brge & (i_flag_gt | i_flag_z));

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle control unit for the 8-bit CPU: sequences fetch, operand fetch,
// execute, memory and input phases and drives the datapath strobes.
// Inputs : clk, reset_n (async active-low), dec_y[26:0] decoder output,
//          mem_ack, in_valid, flag_z, flag_gt.
// Outputs: mem_req, mem_we, addr_sel[1:0], ir_we, imm_we, pc_inc, pc_load,
//          alu_op[2:0], alu_src_imm, reg_we, flags_we, in_ack (combinational
//          from state and inputs), timeout, fault (sticky registers).
// Parameter WAIT_MAX: wait cycles tolerated before timeout (0 disables).
// Build option CPU_CTRL_ONEHOT_CHECK_EN: DECODE faults on a non-one-hot
// class vector; otherwise the lowest set bit wins and all-zero is NOOP.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DEC_W-1:0] dec_y,
  input  logic             mem_ack,
  input  logic             in_valid,
  input  logic             flag_z,
  input  logic             flag_gt,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       addr_sel,
  output logic             ir_we,
  output logic             imm_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic             flags_we,
  output logic             in_ack,
  output logic             timeout,
  output logic             fault
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 2);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_timeout;
  logic               w_waiting;
  logic               w_wait_hit;
  logic               w_to_set;
  logic               w_dec_bad;
  logic [CLS_W-1:0]   w_raw;
  logic [CLS_W-1:0]   w_cls;
  logic               w_two, w_mem, w_inp, w_wr_alu, w_take;
  logic               w_unused_opf;

  // Operand field is consumed by the datapath, not by the sequencer
  assign w_unused_opf = ^dec_y[OPF_MSB:OPF_LSB];

  // Priority-resolved class; all-zero is treated as NOOP
  assign w_raw = dec_y[CLS_W-1:0];
  assign w_cls = (w_raw == '0) ? CLS_W'(1) : lowest_set(w_raw);

  assign w_two    = w_cls[Y_LOADI] | w_cls[Y_ADDI] | w_cls[Y_SUBI] | w_cls[Y_JUMP]
                  | w_cls[Y_BRE] | w_cls[Y_BRNE] | w_cls[Y_BRG] | w_cls[Y_BRGE];
  assign w_mem    = w_cls[Y_LOAD] | w_cls[Y_LOADF] | w_cls[Y_STORE] | w_cls[Y_STOREF];
  assign w_inp    = w_cls[Y_INPUTC] | w_cls[Y_INPUTCF] | w_cls[Y_INPUTD] | w_cls[Y_INPUTDF];
  assign w_wr_alu = w_cls[Y_ADD] | w_cls[Y_ADDI] | w_cls[Y_SUB] | w_cls[Y_SUBI]
                  | w_cls[Y_SHIFTL] | w_cls[Y_SHIFTR] | w_cls[Y_MOVE] | w_cls[Y_LOADI];

  cpu_branch_eval u_branch (
    .i_bre     (w_cls[Y_BRE]),
    .i_brne    (w_cls[Y_BRNE]),
    .i_brg     (w_cls[Y_BRG]),
    .i_brge    (w_cls[Y_BRGE]),
    .i_flag_z  (flag_z),
    .i_flag_gt (flag_gt),
    .o_take    (w_take)
  );

  // Waiting cycle number WAIT_MAX is the one that trips the timeout
  assign w_wait_hit = (WAIT_MAX != 0) && (r_wait_cnt == CNT_W'(WAIT_MAX - 1));
  assign w_to_set   = w_waiting & w_wait_hit;

`ifdef CPU_CTRL_ONEHOT_CHECK_EN
  logic r_fault;
  assign w_dec_bad = ~is_onehot(w_raw);

  // Sticky decode error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_fault <= 1'b0;
    else if ((r_state == ST_DECODE) && w_dec_bad) r_fault <= 1'b1;
  end
  assign fault = r_fault;
`else
  assign w_dec_bad = 1'b0;
  assign fault     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Wait counter: zero whenever not waiting, so every wait state starts from 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     r_wait_cnt <= '0;
    else if (w_waiting && !w_wait_hit) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    else                              r_wait_cnt <= '0;
  end

  // Sticky wait-limit error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_timeout <= 1'b0;
    else if (w_to_set) r_timeout <= 1'b1;
  end
  assign timeout = r_timeout;

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_waiting   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = ADDR_PC;
    ir_we       = 1'b0;
    imm_we      = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    flags_we    = 1'b0;
    in_ack      = 1'b0;

    case (r_state)
      ST_IDLE: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we       = 1'b1;
          pc_inc      = 1'b1;
          w_state_nxt = ST_DECODE;
        end else begin
          w_waiting = 1'b1;
        end
      end
      ST_DECODE: begin
        if (w_dec_bad)  w_state_nxt = ST_HALT;
        else if (w_two) w_state_nxt = ST_OPER;
        else if (w_mem) w_state_nxt = ST_MEM;
        else if (w_inp) w_state_nxt = ST_INWAIT;
        else            w_state_nxt = ST_EXEC;
      end
      ST_OPER: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          imm_we      = 1'b1;
          pc_inc      = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_waiting = 1'b1;
        end
      end
      ST_EXEC: begin
        if (w_cls[Y_ADD] | w_cls[Y_ADDI])      alu_op = ALU_ADD;
        else if (w_cls[Y_SUB] | w_cls[Y_SUBI]) alu_op = ALU_SUB;
        else if (w_cls[Y_SHIFTL])              alu_op = ALU_SHL;
        else if (w_cls[Y_SHIFTR])              alu_op = ALU_SHR;
        else if (w_cls[Y_CMP])                 alu_op = ALU_CMP;
        else if (w_cls[Y_MOVE] | w_cls[Y_LOADI]) alu_op = ALU_PASS;
        reg_we      = w_wr_alu;
        flags_we    = w_wr_alu | w_cls[Y_CMP];
        alu_src_imm = w_cls[Y_ADDI] | w_cls[Y_SUBI] | w_cls[Y_LOADI];
        pc_load     = w_cls[Y_JUMP] | w_take;
        w_state_nxt = ST_FETCH;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_PTR;
        mem_we   = w_cls[Y_STORE] | w_cls[Y_STOREF];
        if (mem_ack) begin
          reg_we      = w_cls[Y_LOAD] | w_cls[Y_LOADF];
          w_state_nxt = ST_FETCH;
        end else begin
          w_waiting = 1'b1;
        end
      end
      ST_INWAIT: begin
        if (in_valid) begin
          in_ack      = 1'b1;
          reg_we      = 1'b1;
          alu_op      = ALU_PASS;
          w_state_nxt = ST_FETCH;
        end else begin
          w_waiting = 1'b1;
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_waiting && w_wait_hit) w_state_nxt = ST_HALT;
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed self-checking bench for cpu_control_fsm. A default instance and a
// WAIT_MAX=4 instance share all inputs; each cycle the full output vector is
// compared against a hand-computed value.
module tb_cpu_control_fsm;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [26:0] dec_y = '0;
  logic        mem_ack = 1'b0;
  logic        in_valid = 1'b0;
  logic        flag_z = 1'b0;
  logic        flag_gt = 1'b0;

  logic        d_mem_req, d_mem_we, d_ir_we, d_imm_we, d_pc_inc, d_pc_load;
  logic        d_alu_src_imm, d_reg_we, d_flags_we, d_in_ack, d_timeout, d_fault;
  logic [1:0]  d_addr_sel;
  logic [2:0]  d_alu_op;
  logic        t_mem_req, t_mem_we, t_ir_we, t_imm_we, t_pc_inc, t_pc_load;
  logic        t_alu_src_imm, t_reg_we, t_flags_we, t_in_ack, t_timeout, t_fault;
  logic [1:0]  t_addr_sel;
  logic [2:0]  t_alu_op;
  logic [16:0] d_obs, t_obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_control_fsm u_dut (
    .clk(clk), .reset_n(reset_n), .dec_y(dec_y), .mem_ack(mem_ack),
    .in_valid(in_valid), .flag_z(flag_z), .flag_gt(flag_gt),
    .mem_req(d_mem_req), .mem_we(d_mem_we), .addr_sel(d_addr_sel),
    .ir_we(d_ir_we), .imm_we(d_imm_we), .pc_inc(d_pc_inc), .pc_load(d_pc_load),
    .alu_op(d_alu_op), .alu_src_imm(d_alu_src_imm), .reg_we(d_reg_we),
    .flags_we(d_flags_we), .in_ack(d_in_ack), .timeout(d_timeout), .fault(d_fault)
  );

  cpu_control_fsm #(.WAIT_MAX(4)) u_to (
    .clk(clk), .reset_n(reset_n), .dec_y(dec_y), .mem_ack(mem_ack),
    .in_valid(in_valid), .flag_z(flag_z), .flag_gt(flag_gt),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .addr_sel(t_addr_sel),
    .ir_we(t_ir_we), .imm_we(t_imm_we), .pc_inc(t_pc_inc), .pc_load(t_pc_load),
    .alu_op(t_alu_op), .alu_src_imm(t_alu_src_imm), .reg_we(t_reg_we),
    .flags_we(t_flags_we), .in_ack(t_in_ack), .timeout(t_timeout), .fault(t_fault)
  );

  assign d_obs = {d_mem_req, d_mem_we, d_addr_sel, d_ir_we, d_imm_we, d_pc_inc, d_pc_load,
                  d_alu_op, d_alu_src_imm, d_reg_we, d_flags_we, d_in_ack, d_timeout, d_fault};
  assign t_obs = {t_mem_req, t_mem_we, t_addr_sel, t_ir_we, t_imm_we, t_pc_inc, t_pc_load,
                  t_alu_op, t_alu_src_imm, t_reg_we, t_flags_we, t_in_ack, t_timeout, t_fault};

  // Expected output vector, same field order as d_obs
  function automatic logic [16:0] ov(input int mreq, input int mwe, input int asel,
                                     input int irwe, input int immwe, input int pcinc,
                                     input int pcld, input int alu, input int srci,
                                     input int rwe, input int fwe, input int inack,
                                     input int tout, input int flt);
    return {1'(mreq), 1'(mwe), 2'(asel), 1'(irwe), 1'(immwe), 1'(pcinc), 1'(pcld),
            3'(alu), 1'(srci), 1'(rwe), 1'(fwe), 1'(inack), 1'(tout), 1'(flt)};
  endfunction

  // Decoder word: one-hot class plus operand nibble in reversed bit order
  function automatic logic [26:0] mk(input int idx, input logic [3:0] nib);
    logic [22:0] oh;
    oh = 23'(1) << idx;
    return {nib[0], nib[1], nib[2], nib[3], oh};
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Settle, compare default instance, advance to just after the next edge
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    chk(tag, d_obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_to(input string tag, input logic [16:0] exp);
    #1;
    chk(tag, t_obs, exp);
    @(posedge clk);
    #1;
  endtask

  // Fetch, decode, operand fetch and execute of a two-byte instruction, zero-wait
  task automatic run_two(input string tag, input logic [26:0] dy, input logic [16:0] exp_exec);
    dec_y   = dy;
    mem_ack = 1'b1;
    cyc({tag, "_fetch"}, ov(1,0,0,1,0,1,0,0,0,0,0,0,0,0));
    cyc({tag, "_dec"},   '0);
    cyc({tag, "_oper"},  ov(1,0,0,0,1,1,0,0,0,0,0,0,0,0));
    cyc({tag, "_exec"},  exp_exec);
  endtask

  initial begin
    logic [16:0] f_ack, f_wait, o_ack;
    f_ack  = ov(1,0,0,1,0,1,0,0,0,0,0,0,0,0);
    f_wait = ov(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    o_ack  = ov(1,0,0,0,1,1,0,0,0,0,0,0,0,0);

    // Reset state
    #3;
    chk("rst_dut", d_obs, '0);
    chk("rst_to",  t_obs, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ADD 0x40, ack tied high
    dec_y   = mk(Y_ADD, 4'h0);
    mem_ack = 1'b1;
    cyc("add_idle",  '0);
    cyc("add_fetch", f_ack);
    cyc("add_dec",   '0);
    cyc("add_exec",  ov(0,0,0,0,0,0,0,0,0,1,1,0,0,0));

    // ADDI 0x50, two wait cycles per access
    mem_ack = 1'b0;
    dec_y   = mk(Y_ADDI, 4'h0);
    cyc("addi_f1", f_wait);
    cyc("addi_f2", f_wait);
    mem_ack = 1'b1;
    cyc("addi_f3", f_ack);
    mem_ack = 1'b0;
    cyc("addi_dec", '0);
    cyc("addi_o1", f_wait);
    cyc("addi_o2", f_wait);
    mem_ack = 1'b1;
    cyc("addi_o3", o_ack);
    mem_ack = 1'b0;
    cyc("addi_exec", ov(0,0,0,0,0,0,0,0,1,1,1,0,0,0));

    // Branches with Z=1, GT=0, then BRNE with Z=0
    flag_z  = 1'b1;
    flag_gt = 1'b0;
    run_two("brge", mk(Y_BRGE, 4'h3), ov(0,0,0,0,0,0,1,0,0,0,0,0,0,0));
    run_two("brg",  mk(Y_BRG,  4'h2), '0);
    run_two("jump", mk(Y_JUMP, 4'h0), ov(0,0,0,0,0,0,1,0,0,0,0,0,0,0));
    flag_z = 1'b0;
    run_two("brne", mk(Y_BRNE, 4'h1), ov(0,0,0,0,0,0,1,0,0,0,0,0,0,0));

    // STORE 0xA0 then LOAD 0x80, one wait each
    dec_y   = mk(Y_STORE, 4'h0);
    cyc("st_fetch", f_ack);
    mem_ack = 1'b0;
    cyc("st_dec",  '0);
    cyc("st_wait", ov(1,1,1,0,0,0,0,0,0,0,0,0,0,0));
    mem_ack = 1'b1;
    cyc("st_ack",  ov(1,1,1,0,0,0,0,0,0,0,0,0,0,0));
    dec_y   = mk(Y_LOAD, 4'h0);
    cyc("ld_fetch", f_ack);
    mem_ack = 1'b0;
    cyc("ld_dec",  '0);
    cyc("ld_wait", ov(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
    mem_ack = 1'b1;
    cyc("ld_ack",  ov(1,0,1,0,0,0,0,0,0,1,0,0,0,0));

    // INPUTD 0x12, in_valid after 5 waiting cycles
    dec_y = mk(Y_INPUTD, 4'h2);
    cyc("in_fetch", f_ack);
    mem_ack = 1'b0;
    cyc("in_dec", '0);
    for (int i = 0; i < 5; i++) cyc("in_wait", '0);
    in_valid = 1'b1;
    cyc("in_ack", ov(0,0,0,0,0,0,0,5,0,1,0,1,0,0));
    in_valid = 1'b0;
    cyc("in_next_fetch", f_wait);

    // Timeout with WAIT_MAX=4 and in_valid held low
    reset_n = 1'b0;
    #1;
    chk("rst2_dut", d_obs, '0);
    chk("rst2_to",  t_obs, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_ack = 1'b1;
    cyc_to("to_idle",  '0);
    cyc_to("to_fetch", f_ack);
    mem_ack = 1'b0;
    cyc_to("to_dec",   '0);
    for (int i = 0; i < 4; i++) cyc_to("to_wait", '0);
    in_valid = 1'b1;
    mem_ack  = 1'b1;
    #1;
    chk("default_no_timeout", 17'(d_timeout), '0);
    for (int i = 0; i < 3; i++) cyc_to("to_halt", ov(0,0,0,0,0,0,0,0,0,0,0,0,1,0));

    // Reset asserted in the middle of OPER
    reset_n = 1'b0;
    #1;
    chk("rst3_to_clears", t_obs, '0);
    @(posedge clk); #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    dec_y    = mk(Y_ADDI, 4'h0);
    cyc("mr_idle",  '0);
    cyc("mr_fetch", f_ack);
    mem_ack = 1'b0;
    cyc("mr_dec",  '0);
    cyc("mr_oper1", f_wait);
    #1;
    chk("mr_oper2", d_obs, f_wait);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_async_drop", d_obs, '0);
    @(posedge clk); #1;
    chk("mr_held", d_obs, '0);
    reset_n = 1'b1;
    cyc("mr_idle2", '0);
    cyc("mr_resume_fetch", f_wait);

    // Two class bits set at once
    dec_y   = 27'h0000003;
    mem_ack = 1'b1;
    cyc("oh_fetch", f_ack);
    mem_ack = 1'b0;
    cyc("oh_dec", '0);
`ifdef CPU_CTRL_ONEHOT_CHECK_EN
    cyc("oh_halt1", ov(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    cyc("oh_halt2", ov(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
`else
    cyc("oh_noop_exec", '0);
    cyc("oh_next_fetch", f_wait);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
